// File: rtl/output_serializer.sv
// Parallel-to-serial output stage: shifts left/right results out MSB-first in lockstep,
// with a one-word pending buffer per channel and a sticky overrun flag.
module output_serializer #(
    parameter int unsigned WIDTH    = 40,
    parameter int unsigned BIT_DIV  = 1,
    parameter int unsigned DIV_BITS = 4
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dataL,
    input  logic [WIDTH-1:0] dataR,
    input  logic             clr_ovr,
    output logic             serial_outL,
    output logic             serial_outR,
    output logic             frame_out,
    output logic             busy,
    output logic             pending,
    output logic             overrun
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [DIV_BITS-1:0] LAST_HOLD = DIV_BITS'(BIT_DIV - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [WIDTH-1:0]    shL;
    logic [WIDTH-1:0]    shR;
    logic [WIDTH-1:0]    pdL;
    logic [WIDTH-1:0]    pdR;
    logic                pendValid;
    logic [CNT_W-1:0]    bitCnt;
    logic [DIV_BITS-1:0] holdCnt;
    logic                holdEnd;
    logic                wordEnd;
    logic                overrunEvent;

    assign holdEnd      = (holdCnt == LAST_HOLD);
    assign wordEnd      = (state == SHIFT) && holdEnd && (bitCnt == '0);
    assign overrunEvent = (state == SHIFT) && load && !wordEnd && pendValid;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (load) stateNext = SHIFT;
            SHIFT: if (wordEnd && !pendValid && !load) stateNext = IDLE;
        endcase
    end

    always_comb begin
        serial_outL = 1'b0;
        serial_outR = 1'b0;
        frame_out   = 1'b0;
        busy        = 1'b0;
        pending     = pendValid;
        if (state == SHIFT) begin
            serial_outL = shL[WIDTH-1];
            serial_outR = shR[WIDTH-1];
            frame_out   = (bitCnt == LAST_BIT);
            busy        = 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            shL       <= '0;
            shR       <= '0;
            pdL       <= '0;
            pdR       <= '0;
            pendValid <= 1'b0;
            bitCnt    <= '0;
            holdCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shL     <= dataL;
                        shR     <= dataR;
                        bitCnt  <= LAST_BIT;
                        holdCnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!holdEnd) begin
                        holdCnt <= holdCnt + DIV_BITS'(1);
                    end else begin
                        holdCnt <= '0;
                        if (bitCnt != '0) begin
                            shL    <= shL << 1;
                            shR    <= shR << 1;
                            bitCnt <= bitCnt - CNT_W'(1);
                        end else if (pendValid) begin
                            // Pending word moves up; a simultaneous load refills the buffer.
                            shL    <= pdL;
                            shR    <= pdR;
                            bitCnt <= LAST_BIT;
                            if (load) begin
                                pdL <= dataL;
                                pdR <= dataR;
                            end else begin
                                pendValid <= 1'b0;
                            end
                        end else if (load) begin
                            shL    <= dataL;
                            shR    <= dataR;
                            bitCnt <= LAST_BIT;
                        end else begin
                            shL <= shL << 1;
                            shR <= shR << 1;
                        end
                    end
                    if (load && !wordEnd && !pendValid) begin
                        pdL       <= dataL;
                        pdR       <= dataR;
                        pendValid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Set has priority over clear when both happen in one cycle.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (overrunEvent) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Testbench for output_serializer: two instances (bit hold 1 and 4) checked against a
// time-slot reference model of the serial streams, pending buffer and overrun flag.
module tb_output_serializer;

    localparam int WIDTH = 40;
    localparam int DIV0  = 1;
    localparam int DIV1  = 4;

    logic             sclk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       ld = '0;
    logic [1:0]       clr = '0;
    logic [WIDTH-1:0] dL [2];
    logic [WIDTH-1:0] dR [2];
    logic [1:0]       sL, sR, fr, bz, pd, ov;

    int tests = 0;
    int fails = 0;

    always #5 sclk = ~sclk;

    output_serializer #(.WIDTH(WIDTH), .BIT_DIV(DIV0), .DIV_BITS(4)) dut0 (
        .sclk(sclk), .reset(rst_n), .load(ld[0]), .dataL(dL[0]), .dataR(dR[0]),
        .clr_ovr(clr[0]), .serial_outL(sL[0]), .serial_outR(sR[0]), .frame_out(fr[0]),
        .busy(bz[0]), .pending(pd[0]), .overrun(ov[0])
    );

    output_serializer #(.WIDTH(WIDTH), .BIT_DIV(DIV1), .DIV_BITS(4)) dut1 (
        .sclk(sclk), .reset(rst_n), .load(ld[1]), .dataL(dL[1]), .dataR(dR[1]),
        .clr_ovr(clr[1]), .serial_outL(sL[1]), .serial_outR(sR[1]), .frame_out(fr[1]),
        .busy(bz[1]), .pending(pd[1]), .overrun(ov[1])
    );

    // Reference model: a word occupies WIDTH*div consecutive cycles; mT counts cycles into it.
    bit               mAct [2];
    int               mT [2];
    logic [WIDTH-1:0] mCurL [2], mCurR [2], mPdL [2], mPdR [2];
    bit               mPv [2];
    bit               mOvr [2];
    bit               ev;

    function automatic int divOf(int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    always @(posedge sclk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mAct[i] = 0; mT[i] = 0; mPv[i] = 0; mOvr[i] = 0;
            end else begin
                ev = 0;
                if (!mAct[i]) begin
                    if (ld[i]) begin
                        mAct[i] = 1; mT[i] = 0; mCurL[i] = dL[i]; mCurR[i] = dR[i];
                    end
                end else if (mT[i] == WIDTH * divOf(i) - 1) begin
                    mT[i] = 0;
                    if (mPv[i]) begin
                        mCurL[i] = mPdL[i]; mCurR[i] = mPdR[i];
                        if (ld[i]) begin mPdL[i] = dL[i]; mPdR[i] = dR[i]; end
                        else mPv[i] = 0;
                    end else if (ld[i]) begin
                        mCurL[i] = dL[i]; mCurR[i] = dR[i];
                    end else begin
                        mAct[i] = 0;
                    end
                end else begin
                    mT[i] = mT[i] + 1;
                    if (ld[i]) begin
                        if (!mPv[i]) begin
                            mPdL[i] = dL[i]; mPdR[i] = dR[i]; mPv[i] = 1;
                        end else begin
                            ev = 1;
                        end
                    end
                end
                if (ev) mOvr[i] = 1;
                else if (clr[i]) mOvr[i] = 0;
            end
        end
    end

    function automatic logic [5:0] expOuts(int i);
        int   idx;
        logic el, er, ef;
        el = 0; er = 0; ef = 0;
        if (mAct[i]) begin
            idx = WIDTH - 1 - mT[i] / divOf(i);
            el  = mCurL[i][idx];
            er  = mCurR[i][idx];
            ef  = (mT[i] < divOf(i));
        end
        return {el, er, ef, mAct[i], mPv[i], mOvr[i]};
    endfunction

    function automatic logic [5:0] outs(int i);
        return {sL[i], sR[i], fr[i], bz[i], pd[i], ov[i]};
    endfunction

    task automatic cycle();
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) cycle();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (outs(i) !== 6'b0) begin
                fails++;
                $display("FAIL reset inst%0d: got %b want %b", i, outs(i), 6'b0);
            end
        end
        rst_n = 1;
        cycle();
    endtask

    task automatic test_single_msb_lsb();
        int busyCnt = 0;
        logic [5:0] o, e;
        dL[0] = 40'h80_0000_0001; dR[0] = '0; ld[0] = 1;
        cycle();
        ld[0] = 0;
        tests++;
        if ({fr[0], sL[0], sR[0]} !== 3'b110) begin
            fails++;
            $display("FAIL single_first inst0: got %b want %b", {fr[0], sL[0], sR[0]}, 3'b110);
        end
        for (int c = 0; c < WIDTH * DIV0 + 4; c++) begin
            o = outs(0); e = expOuts(0);
            if (bz[0]) busyCnt++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL single_stream inst0 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        tests++;
        if (busyCnt != WIDTH * DIV0) begin
            fails++;
            $display("FAIL single_busy_len: got %0d want %0d", busyCnt, WIDTH * DIV0);
        end
    endtask

    task automatic test_hold4();
        int frameCnt = 0, busyCnt = 0;
        logic [5:0] o, e;
        dL[1] = 40'hA5_A5A5_A5A5; dR[1] = $urandom(); ld[1] = 1;
        cycle();
        ld[1] = 0;
        for (int c = 0; c < WIDTH * DIV1 + 6; c++) begin
            o = outs(1); e = expOuts(1);
            if (fr[1]) frameCnt++;
            if (bz[1]) busyCnt++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL hold4_stream inst1 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        tests++;
        if (frameCnt != DIV1) begin
            fails++;
            $display("FAIL hold4_frame_len: got %0d want %0d", frameCnt, DIV1);
        end
        tests++;
        if (busyCnt != WIDTH * DIV1) begin
            fails++;
            $display("FAIL hold4_busy_len: got %0d want %0d", busyCnt, WIDTH * DIV1);
        end
    endtask

    task automatic test_back_to_back();
        int busyCnt = 0;
        logic [5:0] o, e;
        dL[0] = {$urandom(), 8'hC3}; dR[0] = {$urandom(), 8'h5A}; ld[0] = 1;
        cycle();
        ld[0] = 0;
        repeat (9) cycle();
        busyCnt = 10;
        dL[0] = {$urandom(), 8'h81}; dR[0] = {$urandom(), 8'h7E}; ld[0] = 1;
        cycle();
        ld[0] = 0;
        tests++;
        if (pd[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_pending: got %b want %b", pd[0], 1'b1);
        end
        for (int c = 0; c < 2 * WIDTH * DIV0; c++) begin
            o = outs(0); e = expOuts(0);
            if (bz[0]) busyCnt++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_stream inst0 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        tests++;
        if (busyCnt != 2 * WIDTH * DIV0) begin
            fails++;
            $display("FAIL b2b_busy_len: got %0d want %0d", busyCnt, 2 * WIDTH * DIV0);
        end
    endtask

    task automatic test_overrun();
        logic [5:0] o, e;
        for (int k = 0; k < 3; k++) begin
            dL[0] = {$urandom(), 8'(k)}; dR[0] = {$urandom(), 8'(k + 16)}; ld[0] = 1;
            cycle();
            ld[0] = 0;
            if (k < 2) repeat (4) cycle();
        end
        tests++;
        if ({pd[0], ov[0]} !== 2'b11) begin
            fails++;
            $display("FAIL ovr_set: got %b want %b", {pd[0], ov[0]}, 2'b11);
        end
        dL[0] = $urandom(); ld[0] = 1; clr[0] = 1;
        cycle();
        ld[0] = 0; clr[0] = 0;
        tests++;
        if (ov[0] !== 1'b1) begin
            fails++;
            $display("FAIL ovr_set_wins: got %b want %b", ov[0], 1'b1);
        end
        for (int c = 0; c < 2 * WIDTH * DIV0; c++) begin
            o = outs(0); e = expOuts(0);
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL ovr_stream inst0 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        clr[0] = 1;
        cycle();
        clr[0] = 0;
        tests++;
        if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: got %b want %b", ov[0], 1'b0);
        end
    endtask

    task automatic test_bypass();
        int busyCnt = 0;
        logic [5:0] o, e;
        dL[0] = $urandom(); dR[0] = $urandom(); ld[0] = 1;
        cycle();
        ld[0] = 0;
        repeat (WIDTH * DIV0 - 1) cycle();
        dL[0] = {$urandom(), 8'hF0}; dR[0] = {$urandom(), 8'h0F}; ld[0] = 1;
        cycle();
        ld[0] = 0;
        tests++;
        if ({fr[0], bz[0], pd[0], ov[0]} !== 4'b1100) begin
            fails++;
            $display("FAIL bypass_start: got %b want %b", {fr[0], bz[0], pd[0], ov[0]}, 4'b1100);
        end
        for (int c = 0; c < WIDTH * DIV0 + 3; c++) begin
            o = outs(0); e = expOuts(0);
            if (bz[0]) busyCnt++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL bypass_stream inst0 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        tests++;
        if (busyCnt != WIDTH * DIV0) begin
            fails++;
            $display("FAIL bypass_busy_len: got %0d want %0d", busyCnt, WIDTH * DIV0);
        end
    endtask

    task automatic test_reset_mid_word();
        int ones = 0;
        logic [5:0] o, e;
        dL[0] = '1; dR[0] = '1; ld[0] = 1;
        dL[1] = '1; dR[1] = '1; ld[1] = 1;
        cycle();
        ld = '0;
        repeat (20) cycle();
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (outs(i) !== 6'b0) begin
                fails++;
                $display("FAIL async_reset inst%0d: got %b want %b", i, outs(i), 6'b0);
            end
        end
        @(negedge sclk);
        rst_n = 1;
        cycle();
        dL[0] = 40'hFF_FFFF_FFFF; dR[0] = 40'hFF_FFFF_FFFF; ld[0] = 1;
        cycle();
        ld[0] = 0;
        for (int c = 0; c < WIDTH * DIV0 + 2; c++) begin
            o = outs(0); e = expOuts(0);
            if (sL[0] === 1'b1) ones++;
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL post_reset_stream inst0 cyc%0d: got %b want %b", c, o, e);
            end
            cycle();
        end
        tests++;
        if (ones != WIDTH) begin
            fails++;
            $display("FAIL post_reset_ones: got %0d want %0d", ones, WIDTH);
        end
    endtask

    task automatic test_random();
        logic [5:0] o, e;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                ld[i]  = ($urandom_range(0, (i == 0) ? 25 : 90) == 0);
                clr[i] = ($urandom_range(0, 60) == 0);
                dL[i]  = {$urandom(), 8'($urandom())};
                dR[i]  = {$urandom(), 8'($urandom())};
            end
            cycle();
            for (int i = 0; i < 2; i++) begin
                o = outs(i); e = expOuts(i);
                tests++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", i, c, o, e);
                end
            end
        end
        ld = '0; clr = '0;
    endtask

    initial begin
        dL[0] = '0; dL[1] = '0; dR[0] = '0; dR[1] = '0;
        @(negedge sclk);
        test_reset();
        test_single_msb_lsb();
        test_hold4();
        test_back_to_back();
        test_overrun();
        test_bypass();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
